// File: rtl/openddr_addr_mapper.sv
// AXI-to-DDR address mapper: decodes a burst into rank/bank/row/column commands
// and splits bursts at DRAM page boundaries into back-to-back valid/ready commands.
module openddr_addr_mapper #(
  parameter int ADDR_WIDTH  = 40,
  parameter int RANK_WIDTH  = 1,
  parameter int BANK_WIDTH  = 3,
  parameter int ROW_WIDTH   = 16,
  parameter int COL_WIDTH   = 10,
  parameter int BYTE_OFFSET = 3,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cfg_map_mode,
  input  logic                  cfg_xor_en,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [RANK_WIDTH-1:0] cmd_rank,
  output logic [BANK_WIDTH-1:0] cmd_bank,
  output logic [ROW_WIDTH-1:0]  cmd_row,
  output logic [COL_WIDTH-1:0]  cmd_col,
  output logic [COL_WIDTH-1:0]  cmd_len,
  output logic                  cmd_last,
  output logic                  busy
);

  localparam int LW    = ADDR_WIDTH - BYTE_OFFSET;
  localparam int FW    = RANK_WIDTH + BANK_WIDTH + ROW_WIDTH + COL_WIDTH;
  localparam int REM_W = LEN_WIDTH + 1;
  localparam int CW    = (REM_W > COL_WIDTH + 1) ? REM_W : COL_WIDTH + 1;

  if (FW > LW) begin : g_width_check
    $error("openddr_addr_mapper: rank+bank+row+col widths exceed beat address width");
  end

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  typedef struct packed {
    logic [RANK_WIDTH-1:0] rank;
    logic [BANK_WIDTH-1:0] bank;
    logic [ROW_WIDTH-1:0]  row;
    logic [COL_WIDTH-1:0]  col;
    logic [COL_WIDTH-1:0]  len;
    logic                  last;
  } cmd_t;

  // Decode one command from a beat address; the command is clipped at the page end.
  function automatic cmd_t decode(input logic [FW-1:0]    b,
                                  input logic [1:0]       mode,
                                  input logic             xor_en,
                                  input logic [REM_W-1:0] rem);
    cmd_t                  c;
    logic [BANK_WIDTH-1:0] bank_f;
    logic [CW-1:0]         rem_x;
    logic [CW-1:0]         room_x;
    logic [CW-1:0]         take;
    // NOTE: start from known defaults so every path assigns every bit; no latch can form.
    c      = '0;
    bank_f = '0;
    c.col  = b[COL_WIDTH-1:0];
    case (mode)
      2'd1: begin
        c.row  = b[COL_WIDTH +: ROW_WIDTH];
        bank_f = b[COL_WIDTH + ROW_WIDTH +: BANK_WIDTH];
        c.rank = b[COL_WIDTH + ROW_WIDTH + BANK_WIDTH +: RANK_WIDTH];
      end
      2'd2: begin
        c.rank = b[COL_WIDTH +: RANK_WIDTH];
        bank_f = b[COL_WIDTH + RANK_WIDTH +: BANK_WIDTH];
        c.row  = b[COL_WIDTH + RANK_WIDTH + BANK_WIDTH +: ROW_WIDTH];
      end
      default: begin
        bank_f = b[COL_WIDTH +: BANK_WIDTH];
        c.row  = b[COL_WIDTH + BANK_WIDTH +: ROW_WIDTH];
        c.rank = b[COL_WIDTH + BANK_WIDTH + ROW_WIDTH +: RANK_WIDTH];
      end
    endcase
    c.bank = xor_en ? (bank_f ^ c.row[BANK_WIDTH-1:0]) : bank_f;
    rem_x  = CW'(rem);
    room_x = CW'({1'b1, {COL_WIDTH{1'b0}}}) - CW'(c.col);
    if (rem_x <= room_x) begin
      take   = rem_x;
      c.last = 1'b1;
    end else begin
      take   = room_x;
      c.last = 1'b0;
    end
    c.len = COL_WIDTH'(take - CW'(1));
    return c;
  endfunction

  state_t           state;
  logic [LW-1:0]    beat_q;
  logic [REM_W-1:0] rem_q;
  logic [1:0]       mode_q;
  logic             xor_q;
  cmd_t             cmd_q;

  logic [LW-1:0]      req_beat;
  logic [REM_W-1:0]   req_rem;
  logic [COL_WIDTH:0] step;
  logic [LW-1:0]      beat_adv;
  logic [REM_W-1:0]   rem_adv;
  cmd_t               accept_cmd;
  cmd_t               next_cmd;
  logic               unused_byte_bits;

  assign req_beat         = req_addr[ADDR_WIDTH-1:BYTE_OFFSET];
  assign unused_byte_bits = ^req_addr[BYTE_OFFSET-1:0];
  assign req_rem          = REM_W'(req_len) + REM_W'(1);

  // Beat address wraps naturally at the top of the LW-bit space.
  assign step       = {1'b0, cmd_q.len} + (COL_WIDTH + 1)'(1);
  assign beat_adv   = beat_q + LW'(step);
  assign rem_adv    = rem_q - REM_W'(step);
  assign accept_cmd = decode(req_beat[FW-1:0], cfg_map_mode, cfg_xor_en, req_rem);
  assign next_cmd   = decode(beat_adv[FW-1:0], mode_q, xor_q, rem_adv);

  // NOTE: non-blocking assignments make every register update see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
      cmd_q     <= '0;
      beat_q    <= '0;
      rem_q     <= '0;
      mode_q    <= 2'd0;
      xor_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            mode_q    <= cfg_map_mode;
            xor_q     <= cfg_xor_en;
            beat_q    <= req_beat;
            rem_q     <= req_rem;
            cmd_q     <= accept_cmd;
            cmd_valid <= 1'b1;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_valid && cmd_ready) begin
            beat_q <= beat_adv;
            rem_q  <= rem_adv;
            if (cmd_q.last) begin
              cmd_valid <= 1'b0;
              busy      <= 1'b0;
              req_ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              cmd_q <= next_cmd;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_rank = cmd_q.rank;
  assign cmd_bank = cmd_q.bank;
  assign cmd_row  = cmd_q.row;
  assign cmd_col  = cmd_q.col;
  assign cmd_len  = cmd_q.len;
  assign cmd_last = cmd_q.last;

endmodule

// File: tb/tb_openddr_addr_mapper.sv
// Scoreboard bench for openddr_addr_mapper: directed plan cases plus randomized
// bursts checked against an arithmetic reference model.
module tb_openddr_addr_mapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_map_mode;
  logic        cfg_xor_en;
  logic        req_valid;
  logic        req_ready;
  logic [39:0] req_addr;
  logic [7:0]  req_len;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [0:0]  cmd_rank;
  logic [2:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [9:0]  cmd_len;
  logic        cmd_last;
  logic        busy;

  always #5 clk = ~clk;

  openddr_addr_mapper dut (
    .clk(clk), .rst(rst), .cfg_map_mode(cfg_map_mode), .cfg_xor_en(cfg_xor_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rank(cmd_rank), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_len(cmd_len), .cmd_last(cmd_last), .busy(busy)
  );

  typedef struct {
    logic [0:0]  rank;
    logic [2:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
    logic [9:0]  len;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   bp_mode  = 0;
  int   stall    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input int rank, input int bank, input int row,
                                     input int col, input int len, input int last);
    return {23'b0, 1'(rank), 3'(bank), 16'(row), 10'(col), 10'(len), 1'(last)};
  endfunction

  function automatic logic [63:0] pack_exp(input exp_t e);
    return {23'b0, e.rank, e.bank, e.row, e.col, e.len, e.last};
  endfunction

  function automatic logic [63:0] dut_pack();
    return {23'b0, cmd_rank, cmd_bank, cmd_row, cmd_col, cmd_len, cmd_last};
  endfunction

  // Reference model: walk the burst beat by beat range, cutting at each 1024-beat page.
  task automatic model_burst(input logic [39:0] addr, input int len,
                             input logic [1:0] mode, input bit xr);
    longint unsigned beat, rem, col, room, n, rank, bank, row;
    exp_t e;
    beat = {24'b0, addr} >> 3;
    rem  = longint'(len) + 1;
    while (rem > 0) begin
      col  = beat % 1024;
      room = 1024 - col;
      n    = (rem < room) ? rem : room;
      case (mode)
        2'd1: begin
          row  = (beat >> 10) % 65536;
          bank = (beat >> 26) % 8;
          rank = (beat >> 29) % 2;
        end
        2'd2: begin
          rank = (beat >> 10) % 2;
          bank = (beat >> 11) % 8;
          row  = (beat >> 14) % 65536;
        end
        default: begin
          bank = (beat >> 10) % 8;
          row  = (beat >> 13) % 65536;
          rank = (beat >> 29) % 2;
        end
      endcase
      if (xr) bank = bank ^ (row % 8);
      e.rank = 1'(rank);
      e.bank = 3'(bank);
      e.row  = 16'(row);
      e.col  = 10'(col);
      e.len  = 10'(n - 1);
      e.last = (rem == n);
      sb.push_back(e);
      beat = (beat + n) % (64'd1 << 37);
      rem  = rem - n;
    end
  endtask

  task automatic send_req(input logic [39:0] addr, input int len,
                          input logic [1:0] mode, input bit xr);
    logic [63:0] r;
    int cnt = 0;
    while (!req_ready && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", {63'b0, req_ready}, 64'd1);
      return;
    end
    cfg_map_mode = mode;
    cfg_xor_en   = xr;
    req_addr     = addr;
    req_len      = 8'(len);
    req_valid    = 1'b1;
    @(posedge clk);
    model_burst(addr, len, mode, xr);
    #1;
    req_valid    = 1'b0;
    r            = {$urandom, $urandom};
    req_addr     = r[39:0];
    cfg_map_mode = 2'($urandom_range(0, 3));
    cfg_xor_en   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int cyc = 0;
    @(negedge clk);
    while (!(req_ready && !cmd_valid && sb.size() == 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_timeout", {63'b0, (req_ready && !cmd_valid && sb.size() == 0)}, 64'd1);
  endtask

  // Ready driver: always ready, random, or 5 stall cycles per presented command.
  initial begin
    cmd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0: cmd_ready = 1'b1;
        1: cmd_ready = 1'($urandom_range(0, 1));
        default: begin
          if (cmd_valid && stall < 5) begin
            cmd_ready = 1'b0;
            stall++;
          end else begin
            cmd_ready = 1'b1;
            stall     = 0;
          end
        end
      endcase
    end
  end

  // Monitor: every presented command must match the scoreboard head; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && cmd_valid) begin
        check("busy_during_cmd", {63'b0, busy}, 64'd1);
        check("req_ready_during_cmd", {63'b0, req_ready}, 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_cmd", {63'b0, cmd_valid}, 64'd0);
        end else begin
          check("cmd_fields", dut_pack(), pack_exp(sb[0]));
          if (cmd_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic [39:0] a;
    rst          = 1'b1;
    cfg_map_mode = 2'd0;
    cfg_xor_en   = 1'b0;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_len      = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_valid", {63'b0, cmd_valid}, 64'd0);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_req_ready", {63'b0, req_ready}, 64'd0);
    check("reset_fields", dut_pack(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("req_ready_after_reset", {63'b0, req_ready}, 64'd1);

    // Single beat
    bp_mode = 0;
    send_req(40'h2008, 0, 2'd0, 1'b0);
    @(negedge clk);
    check("t1_latency", {63'b0, cmd_valid}, 64'd1);
    check("t1_cmd", dut_pack(), mk(0, 1, 0, 1, 0, 1));
    @(negedge clk);
    check("t1_req_ready_back", {63'b0, req_ready}, 64'd1);
    check("t1_cmd_valid_drop", {63'b0, cmd_valid}, 64'd0);
    check("t1_busy_drop", {63'b0, busy}, 64'd0);

    // Page split, mode 0
    send_req(40'h1FF0, 3, 2'd0, 1'b0);
    @(negedge clk);
    check("t2_cmd_a", dut_pack(), mk(0, 0, 0, 'h3FE, 1, 0));
    @(negedge clk);
    check("t2_no_bubble", {63'b0, cmd_valid}, 64'd1);
    check("t2_cmd_b", dut_pack(), mk(0, 1, 0, 0, 1, 1));
    wait_idle();

    // Page split, mode 1; rank interleave, mode 2
    send_req(40'h1FF0, 3, 2'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t3_mode1_cmd_b", dut_pack(), mk(0, 0, 1, 0, 1, 1));
    wait_idle();
    send_req(40'h2000, 0, 2'd2, 1'b0);
    @(negedge clk);
    check("t3_mode2_cmd", dut_pack(), mk(1, 0, 0, 0, 0, 1));
    wait_idle();

    // XOR hashing on and off
    send_req(40'h54000, 0, 2'd0, 1'b1);
    @(negedge clk);
    check("t4_xor_on", dut_pack(), mk(0, 7, 5, 0, 0, 1));
    wait_idle();
    send_req(40'h54000, 0, 2'd0, 1'b0);
    @(negedge clk);
    check("t4_xor_off", dut_pack(), mk(0, 2, 5, 0, 0, 1));
    wait_idle();

    // Backpressure: monitor verifies stability, busy and req_ready every stalled cycle
    bp_mode = 2;
    send_req(40'h1FF0, 3, 2'd0, 1'b0);
    wait_idle();

    // Wrap at the top of the beat address space
    bp_mode = 0;
    send_req(40'hFF_FFFF_FFF8, 1, 2'd0, 1'b0);
    @(negedge clk);
    check("t5_wrap_top", dut_pack(), mk(1, 7, 'hFFFF, 'h3FF, 0, 0));
    @(negedge clk);
    check("t5_wrap_zero", dut_pack(), mk(0, 0, 0, 0, 0, 1));
    wait_idle();

    // Reset while the first split command is stalled
    bp_mode = 2;
    send_req(40'h1FF0, 3, 2'd0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_cmd_valid_async", {63'b0, cmd_valid}, 64'd0);
    check("t6_busy_async", {63'b0, busy}, 64'd0);
    check("t6_req_ready_in_reset", {63'b0, req_ready}, 64'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_req_ready_after", {63'b0, req_ready}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("t6_no_residual", {63'b0, cmd_valid}, 64'd0);
      @(negedge clk);
    end

    // Randomized bursts with random backpressure and config churn during ISSUE
    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      r = {$urandom, $urandom};
      a = r[39:0];
      if ($urandom_range(0, 2) == 0) a[12:3] = 10'h3F0 + 10'($urandom_range(0, 15));
      send_req(a, $urandom_range(0, 255), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
